// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared constants and state type for the ivl_uvm_ovl monitoring blocks.
package ivl_uvm_ovl_pkg;

  localparam int FIRE_UNDERFLOW = 0;
  localparam int FIRE_XCHECK    = 1;
  localparam int FIRE_COVER     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ARMED = 2'd2
  } ovl_mon_state_e;

endpackage

// File: rtl/ivl_uvm_ovl_sat_counter.sv
// Saturating event counter; clear and a coincident increment combine so the count restarts at 1.
module ivl_uvm_ovl_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ivl_uvm_ovl_underflow_mon.sv
// OVL-style underflow monitor: flags a step from MIN to below MIN or above MAX, plus X/Z samples.
module ivl_uvm_ovl_underflow_mon
  import ivl_uvm_ovl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 4,
  parameter int MAX   = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] test_expr,
  input  logic             clear,
  output logic [2:0]       fire,
  output logic             armed,
  output logic             sticky,
  output logic [CNT_W-1:0] fire_count,
  output logic [WIDTH-1:0] first_fail_value,
  output ovl_mon_state_e   state_dbg
);

  // Handshake: no valid/ready; every output is meaningful every cycle and
  // reflects the sample taken at the previous rising edge.

  if ((MIN > MAX) || (MAX > (2**WIDTH - 1))) begin : g_bad_bounds
    $error("ivl_uvm_ovl_underflow_mon: require MIN <= MAX <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  ovl_mon_state_e   state_q, state_d;
  logic [2:0]       fire_d;
  logic             xz;
  logic             fail;

`ifndef SYNTHESIS
  assign xz = (^test_expr === 1'bx);
`else
  assign xz = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    fire_d  = '0;
    if (enable) begin
      if (xz) begin
        fire_d[FIRE_XCHECK] = 1'b1;
      end else begin
        state_d = (test_expr == MIN_V) ? ARMED : TRACK;
        fire_d[FIRE_COVER] = (test_expr == MIN_V);
        // Only a step taken directly out of MIN is judged.
        fire_d[FIRE_UNDERFLOW] = (state_q == ARMED) &&
                                 ((test_expr < MIN_V) || (test_expr > MAX_V));
      end
    end
  end

  assign fail = fire_d[FIRE_UNDERFLOW] | fire_d[FIRE_XCHECK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fire    <= '0;
    end else begin
      state_q <= state_d;
      fire    <= fire_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky           <= 1'b0;
      first_fail_value <= '0;
    end else begin
      sticky <= clear ? fail : (sticky | fail);
      if (fire_d[FIRE_UNDERFLOW] && (clear || !sticky)) begin
        first_fail_value <= test_expr;
      end else if (clear) begin
        first_fail_value <= '0;
      end
    end
  end

  ivl_uvm_ovl_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (fail),
    .count (fire_count)
  );

  assign armed     = (state_q == ARMED);
  assign state_dbg = state_q;

endmodule
